// File: rtl/peri_hub.sv
// peri_hub: single-outstanding peripheral bus hub with slave decode, timeout and interrupt latching
// Ports: i_clk/i_rst clock and async reset; i_peri_* master request, o_peri_* response and grant;
// o_*_2peri one-hot strobes plus latched address/data/strobes; i_*_2PBUS per-slave data, ready, irq;
// o_irq pending vector (bit 31 = bus error), cleared by i_irq_ack with i_irq_id.
module peri_hub #(
    parameter int          NUM_PERI = 4,
    parameter int          SEL_LSB  = 16,
    parameter int          SEL_W    = 4,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_peri_rden,
    input  logic                   i_peri_wren,
    input  logic [31:0]            i_peri_addr,
    input  logic [31:0]            i_peri_wdata,
    input  logic [3:0]             i_peri_wstrb,
    output logic [31:0]            o_peri_rdata,
    output logic                   o_peri_ready,
    output logic                   o_peri_err,
    output logic                   o_peri_gnt,
    output logic [NUM_PERI-1:0]    o_rden_2peri,
    output logic [NUM_PERI-1:0]    o_wren_2peri,
    output logic [31:0]            o_addr_2peri,
    output logic [31:0]            o_wdata_2peri,
    output logic [3:0]             o_wstrb_2peri,
    input  logic [NUM_PERI*32-1:0] i_rdata_2PBUS,
    input  logic [NUM_PERI-1:0]    i_ready_2PBUS,
    input  logic [NUM_PERI-1:0]    i_int_2PBUS,
    output logic [31:0]            o_irq,
    input  logic                   i_irq_ack,
    input  logic [4:0]             i_irq_id
);
    localparam int IW = (NUM_PERI > 1) ? $clog2(NUM_PERI) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [NUM_PERI-1:0] ONE = NUM_PERI'(1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state_q;
    logic [IW-1:0]       idx_q;
    logic                wr_q;
    logic [CW-1:0]       cnt_q;
    logic [31:0]         rdata_q, addr_q, wdata_q;
    logic [3:0]          wstrb_q;
    logic                ready_q, err_q;
    logic [NUM_PERI-1:0] rden_q, wren_q, int_q;
    logic [31:0]         irq_q, irq_d, irq_set;
    logic [31:0]         ch_rdata [NUM_PERI];
    logic [SEL_W-1:0]    sel;
    logic [IW-1:0]       sel_n;
    logic                dec_err, ch_ready, err_evt;

    for (genvar n = 0; n < NUM_PERI; n++) begin : g_ch
        assign ch_rdata[n] = i_rdata_2PBUS[32*n +: 32];
    end

    assign sel        = i_peri_addr[SEL_LSB +: SEL_W];
    assign sel_n      = sel[IW-1:0];
    assign dec_err    = int'(sel) >= NUM_PERI;
    assign ch_ready   = i_ready_2PBUS[idx_q];
    assign o_peri_gnt = (state_q == IDLE) && (i_peri_rden || i_peri_wren);
    // Error responses are known one edge ahead, so bit 31 rises together with the error response.
    assign err_evt    = (o_peri_gnt && dec_err) || (state_q == WAIT && !ch_ready && cnt_q == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rden_q  <= '0;
            wren_q  <= '0;
        end else begin
            rden_q  <= '0;
            wren_q  <= '0;
            ready_q <= 1'b0;
            case (state_q)
                IDLE: if (o_peri_gnt) begin
                    addr_q  <= i_peri_addr;
                    wdata_q <= i_peri_wdata;
                    wstrb_q <= i_peri_wstrb;
                    wr_q    <= i_peri_wren;
                    idx_q   <= sel_n;
                    cnt_q   <= '0;
                    if (dec_err) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= ERR_DATA;
                    end else begin
                        state_q <= WAIT;
                        wren_q  <= i_peri_wren ? ONE << sel_n : '0;
                        rden_q  <= i_peri_wren ? '0 : ONE << sel_n;
                    end
                end
                WAIT: if (ch_ready) begin
                    state_q <= RESP;
                    ready_q <= 1'b1;
                    err_q   <= 1'b0;
                    rdata_q <= wr_q ? '0 : ch_rdata[idx_q];
                end else if (cnt_q == CNT_LAST) begin
                    state_q <= RESP;
                    ready_q <= 1'b1;
                    err_q   <= 1'b1;
                    rdata_q <= ERR_DATA;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
            endcase
        end
    end

    // Set has priority over acknowledge so a coincident new event is never lost.
    always_comb begin
        irq_set                 = '0;
        irq_set[NUM_PERI-1:0]   = i_int_2PBUS & ~int_q;
        irq_set[31]             = err_evt;
        irq_d                   = (irq_q & ~(i_irq_ack ? 32'd1 << i_irq_id : 32'd0)) | irq_set;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            irq_q <= '0;
            int_q <= '0;
        end else begin
            irq_q <= irq_d;
            int_q <= i_int_2PBUS;
        end
    end

    assign o_peri_rdata  = rdata_q;
    assign o_peri_ready  = ready_q;
    assign o_peri_err    = err_q;
    assign o_rden_2peri  = rden_q;
    assign o_wren_2peri  = wren_q;
    assign o_addr_2peri  = addr_q;
    assign o_wdata_2peri = wdata_q;
    assign o_wstrb_2peri = wstrb_q;
    assign o_irq         = irq_q;
endmodule

// File: tb/tb_peri_hub.sv
// tb_peri_hub: directed self-checking bench for peri_hub with default parameters
module tb_peri_hub;
    logic         clk = 1'b0;
    logic         rst;
    logic         rden, wren;
    logic [31:0]  addr, wdata;
    logic [3:0]   wstrb;
    logic [31:0]  rdata;
    logic         ready, err, gnt;
    logic [3:0]   rd_stb, wr_stb;
    logic [31:0]  a_out, wd_out;
    logic [3:0]   ws_out;
    logic [127:0] s_rdata;
    logic [3:0]   s_ready, s_int;
    logic [31:0]  irq;
    logic         ack;
    logic [4:0]   ack_id;
    int           checks = 0;
    int           errors = 0;

    peri_hub dut (
        .i_clk(clk), .i_rst(rst),
        .i_peri_rden(rden), .i_peri_wren(wren), .i_peri_addr(addr),
        .i_peri_wdata(wdata), .i_peri_wstrb(wstrb),
        .o_peri_rdata(rdata), .o_peri_ready(ready), .o_peri_err(err), .o_peri_gnt(gnt),
        .o_rden_2peri(rd_stb), .o_wren_2peri(wr_stb), .o_addr_2peri(a_out),
        .o_wdata_2peri(wd_out), .o_wstrb_2peri(ws_out),
        .i_rdata_2PBUS(s_rdata), .i_ready_2PBUS(s_ready), .i_int_2PBUS(s_int),
        .o_irq(irq), .i_irq_ack(ack), .i_irq_id(ack_id)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (ready !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL reset_resp got ready=%b err=%b rdata=%h exp 0 0 0", ready, err, rdata); end
        checks++; if (rd_stb !== 4'h0 || wr_stb !== 4'h0 || gnt !== 1'b0) begin errors++; $display("FAIL reset_stb got rd=%b wr=%b gnt=%b exp 0", rd_stb, wr_stb, gnt); end
        checks++; if (a_out !== 32'h0 || wd_out !== 32'h0 || ws_out !== 4'h0 || irq !== 32'h0) begin errors++; $display("FAIL reset_latch got addr=%h wdata=%h wstrb=%h irq=%h exp 0", a_out, wd_out, ws_out, irq); end
        rst = 1'b0;
    endtask

    task automatic test_read_ch1();
        step();
        rden = 1'b1; addr = 32'h0001_0004;
        s_ready = 4'b0010; s_rdata[32 +: 32] = 32'h1234_5678;
        #1;
        checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL rd1_gnt got %b exp 1", gnt); end
        step();
        rden = 1'b0;
        checks++; if (rd_stb !== 4'b0010 || wr_stb !== 4'b0000) begin errors++; $display("FAIL rd1_stb got rd=%b wr=%b exp 0010 0000", rd_stb, wr_stb); end
        checks++; if (a_out !== 32'h0001_0004) begin errors++; $display("FAIL rd1_addr got %h exp 00010004", a_out); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rd1_early got ready=%b exp 0", ready); end
        step();
        s_ready = 4'b0000;
        checks++; if (ready !== 1'b1 || rdata !== 32'h1234_5678 || err !== 1'b0) begin errors++; $display("FAIL rd1_resp got ready=%b rdata=%h err=%b exp 1 12345678 0", ready, rdata, err); end
        step();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rd1_pulse got ready=%b exp 0", ready); end
    endtask

    task automatic test_write_ch3();
        step();
        wren = 1'b1; addr = 32'h0003_0000; wdata = 32'hA5A5_0001; wstrb = 4'b0011;
        #1;
        checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL wr3_gnt got %b exp 1", gnt); end
        step();
        wren = 1'b0; wdata = 32'h0; wstrb = 4'h0; addr = 32'h0;
        checks++; if (wr_stb !== 4'b1000 || rd_stb !== 4'b0000) begin errors++; $display("FAIL wr3_stb got wr=%b rd=%b exp 1000 0000", wr_stb, rd_stb); end
        step();
        checks++; if (wr_stb !== 4'b0000) begin errors++; $display("FAIL wr3_single got wr=%b exp 0000", wr_stb); end
        checks++; if (a_out !== 32'h0003_0000 || wd_out !== 32'hA5A5_0001 || ws_out !== 4'b0011) begin errors++; $display("FAIL wr3_hold got addr=%h wdata=%h wstrb=%b exp 00030000 a5a50001 0011", a_out, wd_out, ws_out); end
        step();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL wr3_early got ready=%b exp 0", ready); end
        step();
        s_ready = 4'b1000; s_rdata[96 +: 32] = 32'hFFFF_FFFF;
        step();
        s_ready = 4'b0000;
        checks++; if (ready !== 1'b1 || err !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL wr3_resp got ready=%b err=%b rdata=%h exp 1 0 0", ready, err, rdata); end
        step();
    endtask

    task automatic test_decode_err();
        step();
        rden = 1'b1; addr = 32'h0007_0000;
        #1;
        checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL dec_gnt got %b exp 1", gnt); end
        step();
        rden = 1'b0;
        checks++; if (rd_stb !== 4'h0 || wr_stb !== 4'h0) begin errors++; $display("FAIL dec_nostb got rd=%b wr=%b exp 0", rd_stb, wr_stb); end
        checks++; if (ready !== 1'b1 || err !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dec_resp got ready=%b err=%b rdata=%h exp 1 1 deadbeef", ready, err, rdata); end
        step();
        checks++; if (irq[31] !== 1'b1) begin errors++; $display("FAIL dec_irq31 got %b exp 1", irq[31]); end
        ack = 1'b1; ack_id = 5'd31;
        step();
        ack = 1'b0;
        checks++; if (irq !== 32'h0) begin errors++; $display("FAIL dec_ack got irq=%h exp 0", irq); end
    endtask

    task automatic test_timeout();
        step();
        rden = 1'b1; addr = 32'h0000_0010;
        step();
        rden = 1'b0;
        checks++; if (rd_stb !== 4'b0001) begin errors++; $display("FAIL to_stb got %b exp 0001", rd_stb); end
        for (int i = 0; i < 254; i++) begin
            step();
            checks++; if (ready !== 1'b0) begin errors++; $display("FAIL to_early cycle %0d got ready=%b exp 0", i + 2, ready); end
        end
        step();
        checks++; if (ready !== 1'b1 || err !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_resp got ready=%b err=%b rdata=%h exp 1 1 deadbeef", ready, err, rdata); end
        for (int i = 0; i < 44; i++) step();
        s_ready = 4'b0001;
        step();
        s_ready = 4'b0000;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL to_late got ready=%b exp 0", ready); end
        ack = 1'b1; ack_id = 5'd31;
        step();
        ack = 1'b0;
        rden = 1'b1; addr = 32'h0000_0000;
        step();
        rden = 1'b0;
        for (int i = 0; i < 254; i++) step();
        s_ready = 4'b0001; s_rdata[0 +: 32] = 32'hCAFE_0000;
        step();
        s_ready = 4'b0000;
        checks++; if (ready !== 1'b1 || err !== 1'b0 || rdata !== 32'hCAFE_0000) begin errors++; $display("FAIL to_edge got ready=%b err=%b rdata=%h exp 1 0 cafe0000", ready, err, rdata); end
        checks++; if (irq !== 32'h0) begin errors++; $display("FAIL to_irq got %h exp 0", irq); end
        step();
    endtask

    task automatic test_back_to_back();
        step();
        rden = 1'b1; wren = 1'b1; addr = 32'h0002_0000; wdata = 32'h0000_00AA; wstrb = 4'hF;
        #1;
        checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt got %b exp 1", gnt); end
        step();
        wren = 1'b0; addr = 32'h0001_0000;
        #1;
        checks++; if (wr_stb !== 4'b0100 || rd_stb !== 4'b0000) begin errors++; $display("FAIL b2b_wins got wr=%b rd=%b exp 0100 0000", wr_stb, rd_stb); end
        checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL b2b_nogntw got %b exp 0", gnt); end
        step();
        s_ready = 4'b0100;
        #1;
        checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL b2b_nogntw2 got %b exp 0", gnt); end
        step();
        s_ready = 4'b0000;
        #1;
        checks++; if (ready !== 1'b1 || rdata !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL b2b_resp got ready=%b rdata=%h err=%b exp 1 0 0", ready, rdata, err); end
        checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL b2b_nogntr got %b exp 0", gnt); end
        step();
        checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL b2b_regnt got %b exp 1", gnt); end
        step();
        rden = 1'b0;
        s_ready = 4'b0010; s_rdata[32 +: 32] = 32'h0BAD_F00D;
        checks++; if (rd_stb !== 4'b0010) begin errors++; $display("FAIL b2b_stb2 got %b exp 0010", rd_stb); end
        step();
        s_ready = 4'b0000;
        checks++; if (ready !== 1'b1 || rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL b2b_resp2 got ready=%b rdata=%h exp 1 0badf00d", ready, rdata); end
        step();
    endtask

    task automatic test_irq();
        step();
        s_int = 4'b0100;
        step();
        checks++; if (irq !== 32'h0000_0004) begin errors++; $display("FAIL irq_set got %h exp 00000004", irq); end
        ack = 1'b1; ack_id = 5'd2;
        step();
        ack = 1'b0; s_int = 4'b0000;
        checks++; if (irq !== 32'h0) begin errors++; $display("FAIL irq_ack got %h exp 0", irq); end
        step();
        s_int = 4'b0100;
        step();
        s_int = 4'b0000;
        checks++; if (irq[2] !== 1'b1) begin errors++; $display("FAIL irq_reset got %b exp 1", irq[2]); end
        step();
        s_int = 4'b0100; ack = 1'b1; ack_id = 5'd2;
        step();
        ack_id = 5'd3;
        checks++; if (irq[2] !== 1'b1) begin errors++; $display("FAIL irq_setwins got %b exp 1", irq[2]); end
        step();
        ack_id = 5'd2;
        checks++; if (irq[2] !== 1'b1) begin errors++; $display("FAIL irq_otherid got %b exp 1", irq[2]); end
        step();
        ack = 1'b0;
        checks++; if (irq !== 32'h0) begin errors++; $display("FAIL irq_clr2 got %h exp 0", irq); end
        ack = 1'b1; ack_id = 5'd10; s_int = 4'b1011;
        step();
        ack = 1'b0;
        checks++; if (irq !== 32'h0000_000B) begin errors++; $display("FAIL irq_multi got %h exp 0000000b", irq); end
        s_int = 4'b0000;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        step();
        rden = 1'b1; addr = 32'h0001_0000;
        step();
        rden = 1'b0;
        checks++; if (rd_stb !== 4'b0010) begin errors++; $display("FAIL rst_stb got %b exp 0010", rd_stb); end
        rst = 1'b1;
        #1;
        checks++; if (rd_stb !== 4'h0 || a_out !== 32'h0 || irq !== 32'h0 || ready !== 1'b0) begin errors++; $display("FAIL rst_async got rd=%b addr=%h irq=%h ready=%b exp 0", rd_stb, a_out, irq, ready); end
        step();
        rst = 1'b0;
        s_ready = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (ready !== 1'b0 || rd_stb !== 4'h0) begin errors++; $display("FAIL rst_noresp cycle %0d got ready=%b rd=%b exp 0 0", i, ready, rd_stb); end
        end
        s_ready = 4'b0000;
    endtask

    initial begin
        rst = 1'b1; rden = 1'b0; wren = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        s_rdata = '0; s_ready = '0; s_int = '0; ack = 1'b0; ack_id = '0;
        test_reset();
        test_read_ch1();
        test_write_ch3();
        test_decode_err();
        test_timeout();
        test_back_to_back();
        test_irq();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
